uart_mem_target: RTL and testbench
==================================

# uart_mem_target

Word-addressed on-chip memory target that sits directly downstream of the UART debug bridge. It consumes the bridge's single-cycle READ/WRITE request pulses and answers with a one-cycle ACK plus registered READ_DATA. It reports BUSY while clearing its contents after reset or servicing a request, so the host busy-check command reflects real state.

## Interface
Parameters:
- DATAW, 32, data word width; must match the bridge.
- ADDRW, 32, request address width; must match the bridge.
- DEPTH_LOG2, 10, log2 of the number of words stored.
- LATENCY, 2, cycles from request accept to ACK; legal range 1..15.
- INIT_VALUE, 0, value written to every word during the post-reset clear.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- READ  in  1  one-cycle read request pulse.
- WRITE  in  1  one-cycle write request pulse.
- ADDRESS  in  ADDRW  word address; sampled with READ/WRITE.
- WRITE_DATA  in  DATAW  write data; sampled with WRITE.
- READ_DATA  out  DATAW  read result; registered, held until the next read ACK.
- ACK  out  1  one-cycle completion pulse for each accepted request.
- BUSY  out  1  high while not ready to accept a request.
- ERR  out  1  sticky protocol/range error flag; cleared only by RST.

## Operation
- States: INIT, IDLE, WAIT, DONE.
- INIT: a clear counter walks addresses 0..2^DEPTH_LOG2-1 and writes INIT_VALUE, one word per cycle. On the last word the block enters IDLE.
- IDLE: on READ or WRITE the block latches the operation, index ADDRESS[DEPTH_LOG2-1:0] and data, and goes to WAIT.
  - Write commits to the RAM in the accept cycle.
  - Read issues to the RAM in the accept cycle.
- WAIT: a latency counter is loaded with LATENCY-1 and decrements. At zero the block goes to DONE. With LATENCY=1, WAIT is skipped and the block goes straight to DONE.
- DONE: ACK=1 for exactly one cycle, READ_DATA is updated if the request was a read, then back to IDLE.
- Out of range (ADDRESS[ADDRW-1:DEPTH_LOG2] nonzero):
  - write is discarded;
  - read returns all-ones;
  - ACK is still given;
  - ERR is set.
- READ and WRITE in the same cycle: handled as a write, the read is dropped, ERR is set.
- Request during WAIT or DONE: ignored, ERR is set.
- Request during INIT: the first one is latched as pending and is serviced in the cycle INIT completes, as if accepted then. Further requests during INIT are dropped and set ERR.
- BUSY = (state != IDLE) or pending.

## Timing
- Reset values: READ_DATA=0, ACK=0, BUSY=1, ERR=0, state=INIT, pending=0.
- INIT lasts exactly 2^DEPTH_LOG2 cycles after the RST deassertion edge.
- Request sampled at edge t gives ACK high during cycle t+LATENCY.
- READ_DATA is valid from the ACK cycle and stable at least through the following cycle, which is when the bridge samples it.
- The next request is accepted no earlier than the cycle after ACK.
- RST asserted mid-operation: back to INIT on the next edge. Any in-flight ACK is suppressed, pending and ERR are cleared, and the clear restarts from address 0.
- Write-then-read to the same word on consecutive accepted requests returns the new data; there is no bypass hazard.

## Configuration
- UART_MEM_TARGET_PARITY_EN defined:
  - each word stores an extra even-parity bit, computed on write and on INIT;
  - on read, a mismatch sets ERR and READ_DATA still returns the stored data.
- Not defined: no parity storage, no parity check; ERR covers only range and protocol errors.

## Structure
- Package uart_mem_target_pkg holds:
  - the state enum (INIT, IDLE, WAIT, DONE);
  - the latency counter width constant (4 bits);
  - the all-ones out-of-range read constant helper.
- Sub-module uart_mem_target_ram: single-port synchronous RAM, width DATAW (+1 with parity), depth 2^DEPTH_LOG2, one-cycle read latency, write-first.
- Top level holds the FSM, the clear counter, the latency counter, pending-request capture and output registers.

## Test plan
- Reset, DEPTH_LOG2=4 -> BUSY=1 for exactly 16 cycles, then 0; a read of address 5 returns INIT_VALUE with ACK at t+2.
- WRITE addr 3 data 0xDEADBEEF, then READ addr 3 -> ACK after each at t+LATENCY; READ_DATA=0xDEADBEEF, held until the next read.
- READ addr 0x0000_0400 with DEPTH_LOG2=10 -> ACK given, READ_DATA=0xFFFFFFFF, ERR=1.
- READ pulse during INIT, then a second READ -> first serviced right after INIT with a single ACK, second dropped, ERR=1.
- RST mid-WAIT -> no ACK, BUSY=1, ERR=0, full clear repeats; a prior written word reads back INIT_VALUE.
- With UART_MEM_TARGET_PARITY_EN, force the stored parity bit flipped on addr 7, then READ -> ACK, stored data returned, ERR=1.

Source files
------------

// File: rtl/uart_mem_target_pkg.sv
// uart_mem_target_pkg: shared types and constants for the UART memory target.
// Holds the FSM state enum, latency counter width and out-of-range fill helper.
package uart_mem_target_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int LAT_W = 4;
  localparam int FILL_MAXW = 64;

  // Mask of w ones, returned in the widest supported word.
  function automatic logic [FILL_MAXW-1:0] oor_fill(input int w);
    logic [FILL_MAXW-1:0] m;
    m = '0;
    for (int i = 0; i < FILL_MAXW; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/uart_mem_target_ram.sv
// uart_mem_target_ram: single-port synchronous RAM, 1-cycle read, write-first.
// Ports: CLK, en, we, addr, din -> dout (registered).
module uart_mem_target_ram #(
  parameter int W  = 32,
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge CLK) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
        dout      <= din;
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/uart_mem_target.sv
// uart_mem_target: word memory behind the UART debug bridge; pulse in, ACK out.
// Ports: CLK, RST, READ, WRITE, ADDRESS, WRITE_DATA -> READ_DATA, ACK, BUSY, ERR.
// Option UART_MEM_TARGET_PARITY_EN: per-word even parity, mismatch sets ERR.
module uart_mem_target
  import uart_mem_target_pkg::*;
#(
  parameter int               DATAW      = 32,
  parameter int               ADDRW      = 32,
  parameter int               DEPTH_LOG2 = 10,
  parameter int               LATENCY    = 2,
  parameter logic [DATAW-1:0] INIT_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             READ,
  input  logic             WRITE,
  input  logic [ADDRW-1:0] ADDRESS,
  input  logic [DATAW-1:0] WRITE_DATA,
  output logic [DATAW-1:0] READ_DATA,
  output logic             ACK,
  output logic             BUSY,
  output logic             ERR
);

`ifdef UART_MEM_TARGET_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int RW = DATAW + PW;
  localparam logic [DATAW-1:0] OOR_DATA =
    DATAW'(oor_fill(DATAW));
  localparam logic [LAT_W-1:0] LAT_LOAD =
    LAT_W'(LATENCY - 1);

  state_t state, state_nx;

  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic [LAT_W-1:0]      lat_cnt;

  logic             pend;
  logic             pend_wr;
  logic [ADDRW-1:0] pend_addr;
  logic [DATAW-1:0] pend_data;

  logic             cur_rd;
  logic             cur_oor;
  logic [DATAW-1:0] rd_q;
  logic             err_q;

  logic             req_in;
  logic             acc;
  logic             op_wr;
  logic [ADDRW-1:0] op_addr;
  logic [DATAW-1:0] op_data;
  logic             op_oor;
  logic             err_set;
  logic             par_bad;
  logic [DATAW-1:0] rd_now;

  logic                  ram_en;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [RW-1:0]         ram_din;
  logic [RW-1:0]         ram_dout;
  logic [RW-1:0]         init_word;
  logic [RW-1:0]         op_word;

  assign req_in = READ | WRITE;
  assign acc    = (state == ST_IDLE) && (pend || req_in);

  // A pending request captured during the clear wins over live inputs.
  assign op_wr   = pend ? pend_wr   : WRITE;
  assign op_addr = pend ? pend_addr : ADDRESS;
  assign op_data = pend ? pend_data : WRITE_DATA;
  assign op_oor  = |op_addr[ADDRW-1:DEPTH_LOG2];

`ifdef UART_MEM_TARGET_PARITY_EN
  assign init_word = {^INIT_VALUE, INIT_VALUE};
  assign op_word   = {^op_data, op_data};
  assign par_bad   = ^ram_dout;
`else
  assign init_word = INIT_VALUE;
  assign op_word   = op_data;
  assign par_bad   = 1'b0;
`endif

  assign ram_en   = (state == ST_INIT) || acc;
  assign ram_we   = (state == ST_INIT)
                 || (acc && op_wr && !op_oor);
  assign ram_addr = (state == ST_INIT)
                  ? clr_cnt
                  : op_addr[DEPTH_LOG2-1:0];
  assign ram_din  = (state == ST_INIT) ? init_word : op_word;

  // RAM output stays put from accept to DONE: nothing else touches it.
  assign rd_now = cur_oor ? OOR_DATA : ram_dout[DATAW-1:0];

  uart_mem_target_ram #(
    .W  (RW),
    .AW (DEPTH_LOG2)
  ) u_ram (
    .CLK  (CLK),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_INIT: if (&clr_cnt) state_nx = ST_IDLE;
      ST_IDLE: begin
        if (acc) begin
          state_nx = (LATENCY == 1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt == LAT_W'(1)) state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_INIT;
    endcase
  end

  always_comb begin
    ACK       = (state == ST_DONE);
    BUSY      = (state != ST_IDLE) || pend;
    ERR       = err_q;
    READ_DATA = rd_q;
    if (state == ST_DONE && cur_rd) READ_DATA = rd_now;
  end

  always_comb begin
    err_set = 1'b0;
    unique case (state)
      ST_INIT: err_set = req_in && (pend || (READ && WRITE));
      ST_IDLE: begin
        err_set = pend ? req_in : (READ && WRITE);
        if (acc && op_oor) err_set = 1'b1;
      end
      ST_WAIT: err_set = req_in;
      ST_DONE: begin
        err_set = req_in;
        if (cur_rd && !cur_oor && par_bad) err_set = 1'b1;
      end
      default: err_set = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      clr_cnt   <= '0;
      lat_cnt   <= '0;
      pend      <= 1'b0;
      pend_wr   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      cur_rd    <= 1'b0;
      cur_oor   <= 1'b0;
      rd_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == ST_INIT) clr_cnt <= clr_cnt + 1'b1;
      if (state == ST_INIT && req_in && !pend) begin
        pend      <= 1'b1;
        pend_wr   <= WRITE;
        pend_addr <= ADDRESS;
        pend_data <= WRITE_DATA;
      end
      if (acc) begin
        pend    <= 1'b0;
        cur_rd  <= !op_wr;
        cur_oor <= op_oor;
        lat_cnt <= LAT_LOAD;
      end else if (state == ST_WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (state == ST_DONE && cur_rd) rd_q <= rd_now;
      if (err_set) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_mem_target.sv
// tb_uart_mem_target: directed self-checking bench for uart_mem_target.
// DEPTH_LOG2=4, LATENCY=2, nonzero INIT_VALUE; parity case under its macro.
module tb_uart_mem_target;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int DL  = 4;
  localparam int LAT = 2;
  localparam logic [31:0] IV = 32'h1234_5678;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          READ = 1'b0;
  logic          WRITE = 1'b0;
  logic [AW-1:0] ADDRESS = '0;
  logic [DW-1:0] WRITE_DATA = '0;
  logic [DW-1:0] READ_DATA;
  logic          ACK;
  logic          BUSY;
  logic          ERR;

  int n_chk  = 0;
  int n_fail = 0;

  uart_mem_target #(
    .DATAW      (DW),
    .ADDRW      (AW),
    .DEPTH_LOG2 (DL),
    .LATENCY    (LAT),
    .INIT_VALUE (IV)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .READ       (READ),
    .WRITE      (WRITE),
    .ADDRESS    (ADDRESS),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .ACK        (ACK),
    .BUSY       (BUSY),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Pulse one request; lat = edges from sampling edge to ACK seen.
  task automatic req(input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] d,
                     output int lat);
    READ = rd;
    WRITE = wr;
    ADDRESS = a;
    WRITE_DATA = d;
    tick();
    READ = 1'b0;
    WRITE = 1'b0;
    lat = 1;
    while (!ACK && lat < 32) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_reset(output int busy_n);
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    busy_n = 0;
    while (BUSY && busy_n < 200) begin
      tick();
      busy_n++;
    end
  endtask

  initial begin
    int lat;
    int n;
    int acks;
    int ack_at;

    RST = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(BUSY), 32'd1);
    check("rst_ack", 32'(ACK), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_rdata", READ_DATA, 32'h0);
    RST = 1'b0;
    n = 0;
    while (BUSY && n < 200) begin
      tick();
      n++;
    end
    check("init_cycles", 32'(n), 32'd16);

    req(1'b1, 1'b0, 32'd5, 32'd0, lat);
    check("rd5_lat", 32'(lat), 32'd2);
    check("rd5_data", READ_DATA, IV);
    tick();
    check("ack_one_cycle", 32'(ACK), 32'd0);
    check("rd5_hold", READ_DATA, IV);
    check("idle_busy", 32'(BUSY), 32'd0);

    req(1'b0, 1'b1, 32'd3, 32'hDEAD_BEEF, lat);
    check("wr3_lat", 32'(lat), 32'd2);
    check("wr_keeps_rdata", READ_DATA, IV);
    tick();
    req(1'b1, 1'b0, 32'd3, 32'd0, lat);
    check("rd3_lat", 32'(lat), 32'd2);
    check("rd3_data", READ_DATA, 32'hDEAD_BEEF);
    tick();
    check("rd3_hold", READ_DATA, 32'hDEAD_BEEF);
    req(1'b0, 1'b1, 32'd4, 32'h0BAD_F00D, lat);
    tick();
    check("rdata_after_wr", READ_DATA, 32'hDEAD_BEEF);
    req(1'b1, 1'b0, 32'd4, 32'd0, lat);
    check("rd4_data", READ_DATA, 32'h0BAD_F00D);
    tick();
    check("no_err_yet", 32'(ERR), 32'd0);

    req(1'b1, 1'b0, 32'h0000_0400, 32'd0, lat);
    check("oor_rd_lat", 32'(lat), 32'd2);
    check("oor_rd_data", READ_DATA, 32'hFFFF_FFFF);
    tick();
    check("oor_err", 32'(ERR), 32'd1);
    req(1'b0, 1'b1, 32'h0000_0013, 32'h1111_1111, lat);
    check("oor_wr_lat", 32'(lat), 32'd2);
    tick();
    req(1'b1, 1'b0, 32'd3, 32'd0, lat);
    check("oor_wr_dropped", READ_DATA, 32'hDEAD_BEEF);
    tick();

    // Requests during the clear: first pending, second dropped.
    RST = 1'b1;
    tick();
    check("rst2_err", 32'(ERR), 32'd0);
    check("rst2_busy", 32'(BUSY), 32'd1);
    RST = 1'b0;
    acks = 0;
    ack_at = 0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 2) begin
        READ = 1'b1;
        ADDRESS = 32'd3;
      end
      if (k == 3) READ = 1'b0;
      if (k == 5) begin
        READ = 1'b1;
        ADDRESS = 32'd4;
      end
      if (k == 6) READ = 1'b0;
      tick();
      if (ACK) begin
        acks++;
        ack_at = k;
      end
    end
    check("pend_acks", 32'(acks), 32'd1);
    check("pend_ack_at", 32'(ack_at), 32'd18);
    check("pend_data", READ_DATA, IV);
    check("pend_err", 32'(ERR), 32'd1);
    check("pend_idle", 32'(BUSY), 32'd0);

    // Reset while a read sits in WAIT.
    req(1'b0, 1'b1, 32'd6, 32'hCAFE_F00D, lat);
    tick();
    READ = 1'b1;
    ADDRESS = 32'd6;
    tick();
    READ = 1'b0;
    RST = 1'b1;
    tick();
    check("midrst_ack", 32'(ACK), 32'd0);
    check("midrst_busy", 32'(BUSY), 32'd1);
    check("midrst_err", 32'(ERR), 32'd0);
    RST = 1'b0;
    n = 0;
    acks = 0;
    while (BUSY && n < 200) begin
      tick();
      n++;
      if (ACK) acks++;
    end
    check("midrst_clear", 32'(n), 32'd16);
    check("midrst_no_ack", 32'(acks), 32'd0);
    req(1'b1, 1'b0, 32'd6, 32'd0, lat);
    check("midrst_rd6", READ_DATA, IV);
    tick();
    check("midrst_err2", 32'(ERR), 32'd0);

    // READ and WRITE together act as a write.
    req(1'b1, 1'b1, 32'd8, 32'hA5A5_A5A5, lat);
    check("both_lat", 32'(lat), 32'd2);
    check("both_no_rd", READ_DATA, IV);
    tick();
    check("both_err", 32'(ERR), 32'd1);
    req(1'b1, 1'b0, 32'd8, 32'd0, lat);
    check("both_wrote", READ_DATA, 32'hA5A5_A5A5);
    tick();

    // Second request while in WAIT is ignored.
    do_reset(n);
    check("rst3_clear", 32'(n), 32'd16);
    check("rst3_err", 32'(ERR), 32'd0);
    WRITE = 1'b1;
    ADDRESS = 32'd9;
    WRITE_DATA = 32'h0000_0001;
    tick();
    WRITE_DATA = 32'h0000_0002;
    tick();
    WRITE = 1'b0;
    check("busy_req_ack", 32'(ACK), 32'd1);
    tick();
    check("busy_req_one_ack", 32'(ACK), 32'd0);
    check("busy_req_err", 32'(ERR), 32'd1);
    req(1'b1, 1'b0, 32'd9, 32'd0, lat);
    check("busy_req_data", READ_DATA, 32'h0000_0001);
    tick();

`ifdef UART_MEM_TARGET_PARITY_EN
    do_reset(n);
    dut.u_ram.mem[7][DW] = ~dut.u_ram.mem[7][DW];
    req(1'b1, 1'b0, 32'd7, 32'd0, lat);
    check("par_lat", 32'(lat), 32'd2);
    check("par_data", READ_DATA, IV);
    tick();
    check("par_err", 32'(ERR), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
